usb_port_arbiter: RTL and testbench

USB_PORT_ARBITER -- requirements
Module: usb_port_arbiter

---
 rtl/usb_port_arbiter_if.sv | 33 +++
 rtl/usb_port_arbiter.sv | 133 +++++++++++++
 tb/tb_usb_port_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/usb_port_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals around the USB port arbiter.
// The arbiter uses the slave view; whatever drives the ports and the FIFO flag uses master.
interface usb_port_arbiter_if #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_PKT_LEN = 64
);
  localparam int unsigned LenW = $clog2(MAX_PKT_LEN) + 1;

  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data;
  logic [NUM_PORTS-1:0]            port_valid;
  logic [NUM_PORTS-1:0]            port_last;
  logic [NUM_PORTS-1:0]            port_ready;
  logic [DATA_WIDTH-1:0]           fifo_w_data;
  logic                            fifo_wr_en;
  logic                            fifo_full;
  logic [NUM_PORTS-1:0]            grant;
  logic                            busy;
  logic                            pkt_done;
  logic [LenW-1:0]                 pkt_len;
  logic                            err_overlen;

  modport master (
    output req, port_data, port_valid, port_last, fifo_full,
    input  port_ready, fifo_w_data, fifo_wr_en, grant, busy, pkt_done, pkt_len, err_overlen
  );

  modport slave (
    input  req, port_data, port_valid, port_last, fifo_full,
    output port_ready, fifo_w_data, fifo_wr_en, grant, busy, pkt_done, pkt_len, err_overlen
  );
endinterface

// File: rtl/usb_port_arbiter.sv
// Round-robin arbiter that lets one downstream port at a time stream a packet into a shared
// FIFO write port. Packets longer than MAX_PKT_LEN are truncated; the excess is drained.
module usb_port_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_PKT_LEN = 64
) (
  input logic               clk,
  input logic               rst,
  usb_port_arbiter_if.slave arb_if
);
  localparam int unsigned LenW = $clog2(MAX_PKT_LEN) + 1;
  localparam int unsigned PtrW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [LenW-1:0] MaxLen = LenW'(MAX_PKT_LEN);

  typedef enum logic [1:0] {StIdle, StXfer, StDrain} state_e;

  state_e                state_q, state_d;
  logic [NUM_PORTS-1:0]  grant_q, grant_d;
  logic [PtrW-1:0]       owner_q, owner_d;  // current owner, doubles as last winner
  logic [LenW-1:0]       cnt_q, cnt_d;
  logic [LenW-1:0]       pkt_len_q, pkt_len_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  err_q, err_d;

  logic [PtrW-1:0]       win;
  logic                  win_found;
  int unsigned           idx;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  owner_valid;
  logic                  owner_last;
  logic [NUM_PORTS-1:0]  ready;
  logic                  wr_en;

  assign owner_data  = arb_if.port_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
  assign owner_valid = arb_if.port_valid[owner_q];
  assign owner_last  = arb_if.port_last[owner_q];

  // Round-robin search beginning one past the previous winner, wrapping around.
  always_comb begin
    win       = owner_q;
    win_found = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(owner_q) + i) % NUM_PORTS;
      if (!win_found && arb_if.req[idx]) begin
        win_found = 1'b1;
        win       = PtrW'(idx);
      end
    end
  end

  // Next-state and datapath steering for the IDLE/XFER/DRAIN sequence.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    pkt_len_d  = pkt_len_q;
    pkt_done_d = 1'b0;
    err_d      = 1'b0;
    ready      = '0;
    wr_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (win_found) begin
          grant_d = NUM_PORTS'(1) << win;
          owner_d = win;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        ready[owner_q] = ~arb_if.fifo_full;
        wr_en          = owner_valid & ~arb_if.fifo_full;
        if (wr_en) begin
          cnt_d = cnt_q + 1'b1;
          if (owner_last) begin
            state_d    = StIdle;
            grant_d    = '0;
            pkt_done_d = 1'b1;
            pkt_len_d  = cnt_q + 1'b1;
          end else if (cnt_q + 1'b1 == MaxLen) begin
            state_d = StDrain;
            err_d   = 1'b1;
          end
        end
      end
      StDrain: begin
        // Excess bytes are swallowed without touching the FIFO.
        ready[owner_q] = 1'b1;
        if (owner_valid && owner_last) begin
          state_d    = StIdle;
          grant_d    = '0;
          pkt_done_d = 1'b1;
          pkt_len_d  = MaxLen;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset makes port NUM_PORTS-1 the last winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      owner_q    <= PtrW'(NUM_PORTS - 1);
      cnt_q      <= '0;
      pkt_len_q  <= '0;
      pkt_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      pkt_len_q  <= pkt_len_d;
      pkt_done_q <= pkt_done_d;
      err_q      <= err_d;
    end
  end

  assign arb_if.port_ready  = ready;
  assign arb_if.fifo_wr_en  = wr_en;
  assign arb_if.fifo_w_data = (state_q == StXfer) ? owner_data : '0;
  assign arb_if.grant       = grant_q;
  assign arb_if.busy        = (state_q != StIdle);
  assign arb_if.pkt_done    = pkt_done_q;
  assign arb_if.pkt_len     = pkt_len_q;
  assign arb_if.err_overlen = err_q;
endmodule

// File: tb/tb_usb_port_arbiter.sv
// Directed bench for usb_port_arbiter with 4 ports, 8-bit bytes and MAX_PKT_LEN = 4.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_usb_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   err_cnt = 0;
  int   wr_base;
  int   err_base;

  usb_port_arbiter_if #(.NUM_PORTS(4), .DATA_WIDTH(8), .MAX_PKT_LEN(4)) bus ();

  usb_port_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8), .MAX_PKT_LEN(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus)
  );

  always #5 clk = ~clk;

  // Count FIFO writes and overlength pulses seen at each rising edge.
  always @(posedge clk) begin
    if (bus.fifo_wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
    if (bus.err_overlen === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte on port p, then check the combinational handshake and grant.
  task automatic byte_step(input int p, input logic [7:0] d, input logic l, input logic full,
                           input logic exp_wr, input logic [3:0] exp_rdy,
                           input logic [3:0] exp_gnt);
    @(negedge clk);
    bus.port_valid = '0;
    bus.port_last  = '0;
    bus.port_valid[p] = 1'b1;
    bus.port_last[p]  = l;
    bus.port_data[p*8 +: 8] = d;
    bus.fifo_full = full;
    #1;
    chk("grant", {28'd0, bus.grant}, {28'd0, exp_gnt});
    chk("fifo_wr_en", {31'd0, bus.fifo_wr_en}, {31'd0, exp_wr});
    chk("port_ready", {28'd0, bus.port_ready}, {28'd0, exp_rdy});
    if (exp_wr) chk("fifo_w_data", {24'd0, bus.fifo_w_data}, {24'd0, d});
  endtask

  // The cycle after the last byte: completion pulse, length, and back in IDLE.
  task automatic end_check(input logic [2:0] exp_len);
    @(negedge clk);
    bus.port_valid = '0;
    bus.port_last  = '0;
    bus.fifo_full  = 1'b0;
    #1;
    chk("pkt_done", {31'd0, bus.pkt_done}, 32'd1);
    chk("pkt_len", {29'd0, bus.pkt_len}, {29'd0, exp_len});
    chk("grant_idle", {28'd0, bus.grant}, 32'd0);
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_grant"}, {28'd0, bus.grant}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.pkt_done}, 32'd0);
    chk({tag, "_len"}, {29'd0, bus.pkt_len}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.err_overlen}, 32'd0);
    chk({tag, "_ready"}, {28'd0, bus.port_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, bus.fifo_wr_en}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, bus.fifo_w_data}, 32'd0);
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    bus.req = '0;
    bus.port_data = '0;
    bus.port_valid = '0;
    bus.port_last = '0;
    bus.fifo_full = 1'b0;

    // Reset: request asserted during reset must not leak through.
    repeat (2) @(negedge clk);
    bus.req = 4'b0100;
    #1;
    all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;

    // Fairness: all ports requesting, 1-byte packets, order 0,1,2,3,0 with an IDLE gap.
    @(negedge clk);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      byte_step(order[k], 8'h10 + 8'(k), 1'b1, 1'b0, 1'b1, 4'(1 << order[k]),
                4'(1 << order[k]));
      if (k == 4) bus.req = '0;
      end_check(3'd1);
    end

    // Single port 2, three bytes.
    wr_base = wr_cnt;
    @(negedge clk);
    bus.req = 4'b0100;
    byte_step(2, 8'hA1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100);
    bus.req = '0;
    byte_step(2, 8'hA2, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100);
    byte_step(2, 8'hA3, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0100);
    end_check(3'd3);
    chk("single_writes", wr_cnt - wr_base, 32'd3);
    @(negedge clk);
    #1;
    chk("pkt_done_pulse", {31'd0, bus.pkt_done}, 32'd0);

    // Backpressure on port 3: FIFO full for two cycles while B2 is offered.
    wr_base = wr_cnt;
    err_base = err_cnt;
    bus.req = 4'b1000;
    byte_step(3, 8'hB1, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b1000);
    bus.req = '0;
    byte_step(3, 8'hB2, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000);
    byte_step(3, 8'hB2, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000);
    byte_step(3, 8'hB2, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b1000);
    byte_step(3, 8'hB3, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b1000);
    byte_step(3, 8'hB4, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b1000);
    end_check(3'd4);
    chk("bp_writes", wr_cnt - wr_base, 32'd4);

    // Exact-length packet (4 bytes, max 4): last winner 3, so port 0 beats port 1.
    @(negedge clk);
    bus.req = 4'b0011;
    byte_step(0, 8'hD1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001);
    bus.req = '0;
    byte_step(0, 8'hD2, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001);
    byte_step(0, 8'hD3, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001);
    byte_step(0, 8'hD4, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001);
    end_check(3'd4);
    chk("exact_no_err", err_cnt - err_base, 32'd0);

    // Overlength on port 1: 6 bytes, only 4 written, then drained even with FIFO full.
    wr_base = wr_cnt;
    err_base = err_cnt;
    @(negedge clk);
    bus.req = 4'b0010;
    byte_step(1, 8'hC1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010);
    bus.req = '0;
    byte_step(1, 8'hC2, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010);
    byte_step(1, 8'hC3, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010);
    byte_step(1, 8'hC4, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010);
    byte_step(1, 8'hC5, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010);
    chk("err_pulse_hi", {31'd0, bus.err_overlen}, 32'd1);
    chk("drain_busy", {31'd0, bus.busy}, 32'd1);
    byte_step(1, 8'hC6, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b0010);
    chk("err_pulse_lo", {31'd0, bus.err_overlen}, 32'd0);
    end_check(3'd4);
    chk("over_writes", wr_cnt - wr_base, 32'd4);
    chk("over_err_count", err_cnt - err_base, 32'd1);

    // Reset mid-packet: port 0 owns (search from 2 wraps to 0), reset after 2 of 5 bytes.
    err_base = err_cnt;
    @(negedge clk);
    bus.req = 4'b0001;
    byte_step(0, 8'hE1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001);
    bus.req = '0;
    byte_step(0, 8'hE2, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001);
    @(negedge clk);
    bus.port_data[7:0] = 8'hE3;
    rst = 1'b1;
    #1;
    all_zero("midrst");
    @(negedge clk);
    #1;
    all_zero("midrst2");
    // After release port 0 is searched first again; port 1 follows on re-arbitration.
    @(negedge clk);
    rst = 1'b0;
    bus.port_valid = '0;
    bus.port_last = '0;
    bus.req = 4'b0011;
    byte_step(0, 8'hF0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001);
    end_check(3'd1);
    byte_step(1, 8'hF1, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0010);
    bus.req = '0;
    end_check(3'd1);
    chk("rst_no_err", err_cnt - err_base, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
